// File: rtl/output_module_pkg.sv
// Shared router definitions: direction codes and flit-width defaults used by
// the output port and its round-robin arbiter.
package output_module_pkg;

  typedef enum logic [2:0] {
    DIR_N       = 3'd0,
    DIR_S       = 3'd1,
    DIR_E       = 3'd2,
    DIR_W       = 3'd3,
    DIR_L       = 3'd4,
    DIR_INVALID = 3'd7
  } dir_e;

  localparam int NUM_PORTS    = 5;
  localparam int DIR_W_BITS   = 3;
  localparam int MSB_SLOT_DEF = 5;
  localparam int DSIZE_DEF    = 1 << MSB_SLOT_DEF;

endpackage

// File: rtl/output_module_rr_arbiter.sv
// Round-robin arbiter over the five input modules; the search starts just
// after the last granted index and nothing is granted while en_i is low.
module rr_arbiter
  import output_module_pkg::*;
#(
  parameter int N  = NUM_PORTS,
  parameter int IW = DIR_W_BITS
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int cand;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned infers a latch.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(last_i) + off;
      if (cand >= N) cand = cand - N;
      if (cand >= N) cand = cand - N;
      // An X request bit fails this test and so can never produce an X grant.
      if (!valid_o && en_i && (req_i[cand] === 1'b1)) begin
        valid_o = 1'b1;
        idx_o   = IW'(cand);
      end
    end
    if (valid_o) grant_o = N'(1) << idx_o;
  end

endmodule

// File: rtl/output_module.sv
// Router output port: round-robin grant among the five input modules into a
// small show-ahead FIFO read by the next router through an empty/read handshake.
module output_module
  import output_module_pkg::*;
#(
  parameter int           MSB_SLOT  = MSB_SLOT_DEF,
  parameter int           DSIZE     = 1 << MSB_SLOT,
  parameter int           DEPTH_LOG = 2,
  parameter logic [2:0]   PORT      = 3'b000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      req,
  input  logic [NUM_PORTS*DSIZE-1:0] req_data,
  output logic [NUM_PORTS-1:0]      grant,
  output logic                      output_empty,
  input  logic                      output_read,
  output logic [DSIZE-1:0]          data_out,
  output logic [DEPTH_LOG:0]        occupancy
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  // A flit never turns back toward the port it came from, except at Local.
  localparam logic [NUM_PORTS-1:0] ELIGIBLE =
    (PORT == 3'(DIR_L)) ? '1 : ~(NUM_PORTS'(1) << PORT);

  logic [DSIZE-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG:0]    count_q, count_d;
  logic [DIR_W_BITS-1:0] last_grant_q;

  logic [NUM_PORTS-1:0]  eff_req;
  logic [DIR_W_BITS-1:0] grant_idx;
  logic                  grant_valid;
  logic                  full;
  logic                  do_read;
  logic [DSIZE-1:0]      wr_data;

  assign eff_req = req & ELIGIBLE;
  assign full    = (count_q == (DEPTH_LOG+1)'(DEPTH));
  assign do_read = output_read && (count_q != '0);

  rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (DIR_W_BITS)
  ) u_arb (
    .req_i   (eff_req),
    .last_i  (last_grant_q),
    .en_i    (!full && !reset),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .valid_o (grant_valid)
  );

  always_comb begin
    case (grant_idx)
      3'd0:    wr_data = req_data[0*DSIZE +: DSIZE];
      3'd1:    wr_data = req_data[1*DSIZE +: DSIZE];
      3'd2:    wr_data = req_data[2*DSIZE +: DSIZE];
      3'd3:    wr_data = req_data[3*DSIZE +: DSIZE];
      3'd4:    wr_data = req_data[4*DSIZE +: DSIZE];
      default: wr_data = '0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({grant_valid, do_read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 3'(DIR_L);
      // NOTE: the storage is reset because data_out reads it directly and
      // must show zero after reset; a larger FIFO would gate data_out instead.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (grant_valid) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + DEPTH_LOG'(1);
        last_grant_q    <= grant_idx;
      end
      if (do_read) rd_ptr_q <= rd_ptr_q + DEPTH_LOG'(1);
      count_q <= count_d;
    end
  end

  assign output_empty = (count_q == '0);
  assign data_out     = mem_q[rd_ptr_q];
  assign occupancy    = count_q;

endmodule

// File: tb/tb_output_module.sv
// Bench for output_module: an East port (PORT=2) and a Local port (PORT=4)
// share clock and reset; a per-instance queue holds the flits each should emit.
module tb_output_module;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   req_v    [2];
  logic [159:0] data_v   [2];
  logic         rd_v     [2];
  logic [4:0]   grant_w  [2];
  logic         empty_w  [2];
  logic [31:0]  dout_w   [2];
  logic [2:0]   occ_w    [2];

  logic [31:0]  sb_e[$];
  logic [31:0]  sb_l[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           stamp    = 0;

  always #5 clk = ~clk;

  output_module #(.PORT(3'd2)) u_dut_e (
    .clk          (clk),
    .reset        (reset),
    .req          (req_v[0]),
    .req_data     (data_v[0]),
    .grant        (grant_w[0]),
    .output_empty (empty_w[0]),
    .output_read  (rd_v[0]),
    .data_out     (dout_w[0]),
    .occupancy    (occ_w[0])
  );

  output_module #(.PORT(3'd4)) u_dut_l (
    .clk          (clk),
    .reset        (reset),
    .req          (req_v[1]),
    .req_data     (data_v[1]),
    .grant        (grant_w[1]),
    .output_empty (empty_w[1]),
    .output_read  (rd_v[1]),
    .data_out     (dout_w[1]),
    .occupancy    (occ_w[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle on instance d, entered and left at a falling edge.
  task automatic cyc(input int d, input logic [4:0] r, input logic rd,
                     input logic [4:0] exp_g, input string tag);
    int          size;
    logic [31:0] front;
    int          gi;
    stamp++;
    req_v[d] = r;
    rd_v[d]  = rd;
    for (int i = 0; i < 5; i++)
      data_v[d][i*32 +: 32] = {8'hA0 + 8'(d), 8'(stamp), 8'h00, 8'(i)};
    #1;
    size  = (d == 0) ? sb_e.size() : sb_l.size();
    front = (size == 0) ? 32'h0 : ((d == 0) ? sb_e[0] : sb_l[0]);
    check({tag, " grant"}, 32'(grant_w[d]), 32'(exp_g));
    check({tag, " occupancy"}, 32'(occ_w[d]), 32'(size));
    check({tag, " empty"}, 32'(empty_w[d]), 32'(size == 0));
    if (size > 0) check({tag, " data_out"}, dout_w[d], front);
    if (rd && size > 0) begin
      if (d == 0) void'(sb_e.pop_front());
      else        void'(sb_l.pop_front());
    end
    gi = -1;
    for (int i = 0; i < 5; i++) if (exp_g[i]) gi = i;
    if (gi >= 0) begin
      if (d == 0) sb_e.push_back(data_v[d][gi*32 +: 32]);
      else        sb_l.push_back(data_v[d][gi*32 +: 32]);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, " grant"}, 32'(grant_w[d]), 32'h0);
      check({tag, " empty"}, 32'(empty_w[d]), 32'h1);
      check({tag, " occupancy"}, 32'(occ_w[d]), 32'h0);
      check({tag, " data_out"}, dout_w[d], 32'h0);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = '0; data_v[d] = '0; rd_v[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    reset = 1'b0;

    // Idle after reset on the East port.
    for (int k = 0; k < 10; k++) cyc(0, 5'b00000, 1'b0, 5'b00000, "idle");

    // Single North flit, then drain and an ignored read on empty.
    cyc(0, 5'b00001, 1'b0, 5'b00001, "single_wr");
    cyc(0, 5'b00000, 1'b0, 5'b00000, "single_vis");
    cyc(0, 5'b00000, 1'b1, 5'b00000, "single_rd");
    cyc(0, 5'b00000, 1'b1, 5'b00000, "empty_rd");
    cyc(0, 5'b00000, 1'b0, 5'b00000, "empty_after");

    // East requesting the East port is never granted, even with X there.
    for (int k = 0; k < 8; k++) cyc(0, 5'b00100, 1'b0, 5'b00000, "uturn");
    cyc(0, 5'b00x01, 1'b0, 5'b00001, "uturn_x");
    cyc(0, 5'b00000, 1'b1, 5'b00000, "uturn_drain");
    cyc(0, 5'b00000, 1'b0, 5'b00000, "uturn_idle");

    // Fill to four, blocked while full, resume the cycle after the first read.
    for (int k = 0; k < 6; k++)
      cyc(0, 5'b00010, 1'b0, (k < 4) ? 5'b00010 : 5'b00000, "fill");
    cyc(0, 5'b00010, 1'b1, 5'b00000, "full_rd");
    for (int k = 0; k < 3; k++) cyc(0, 5'b00010, 1'b1, 5'b00010, "rd_wr");
    for (int k = 0; k < 4; k++) cyc(0, 5'b00000, 1'b1, 5'b00000, "drain");
    cyc(0, 5'b00000, 1'b0, 5'b00000, "drained");

    // All five requesting the Local port: strict N,S,E,W,L rotation.
    for (int k = 0; k < 15; k++)
      cyc(1, 5'b11111, 1'b1, 5'(1 << (k % 5)), "fair");
    cyc(1, 5'b00000, 1'b1, 5'b00000, "fair_drain");
    cyc(1, 5'b00000, 1'b0, 5'b00000, "fair_idle");

    // Asynchronous reset with three flits stored.
    for (int k = 0; k < 3; k++) cyc(1, 5'b00001, 1'b0, 5'b00001, "pre_rst");
    check("pre_rst occupancy", 32'(occ_w[1]), 32'd3);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    sb_e.delete();
    sb_l.delete();
    @(negedge clk);
    check_reset_outputs("rst_held");
    reset = 1'b0;
    cyc(1, 5'b00000, 1'b1, 5'b00000, "post_rst_rd");
    cyc(1, 5'b00000, 1'b0, 5'b00000, "post_rst_idle");
    cyc(1, 5'b10001, 1'b0, 5'b00001, "post_rst_prio");
    cyc(1, 5'b00000, 1'b1, 5'b00000, "post_rst_pop");
    cyc(1, 5'b00000, 1'b0, 5'b00000, "post_rst_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
